// File: rtl/traffic_pe.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pe
// Brief    : NoC traffic generator/checker PE: paced injection with valid/ready,
//            per-source ordering check and end-to-end latency statistics.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_pe #(
  parameter int          xcord        = 0,
  parameter int          ycord        = 0,
  parameter int          X            = 4,
  parameter int          Y            = 4,
  parameter int          dest_x       = 2,
  parameter int          dest_y       = 2,
  parameter int          source_x     = 8,
  parameter int          source_y     = 8,
  parameter int          data_width   = 240,
  parameter int          total_width  = dest_x + dest_y + source_x + source_y + data_width,
  parameter int          num_of_pckts = 3,
  parameter logic [15:0] lfsr_seed    = 16'hACE1 ^ 16'(ycord * X + xcord)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   enable_send,
  input  logic [2:0]             mode,
  input  logic [7:0]             i_rate,
  output logic [total_width-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic [total_width-1:0] i_data,
  input  logic                   i_valid,
  output logic                   done,
  output logic [31:0]            sent_count,
  output logic [31:0]            received_count,
  output logic [31:0]            stall_count,
  output logic [47:0]            latency_sum,
  output logic [31:0]            max_latency,
  output logic                   seq_error
);

  localparam int c_nodes  = X * Y;
  localparam int c_iw     = (c_nodes > 1) ? $clog2(c_nodes) : 1;
  localparam int c_sx_off = dest_x + dest_y;
  localparam int c_sy_off = c_sx_off + source_x;
  localparam int c_pl_off = c_sy_off + source_y;

  localparam logic [dest_x-1:0] c_self_x  = dest_x'(xcord % X);
  localparam logic [dest_y-1:0] c_self_y  = dest_y'(ycord % Y);
  localparam logic [dest_x-1:0] c_right_x = dest_x'((xcord + 1) % X);
  localparam logic [dest_y-1:0] c_top_y   = dest_y'((ycord + 1) % Y);
  localparam logic [dest_x-1:0] c_tr_x    = dest_x'(ycord % X);
  localparam logic [dest_y-1:0] c_tr_y    = dest_y'(xcord % Y);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 r_state;
  logic [7:0]             r_tick;
  logic [31:0]            r_cycle;
  logic [31:0]            r_loaded;
  logic [15:0]            r_lfsr;
  logic [15:0]            r_tx_seq [c_nodes];
  logic [15:0]            r_rx_exp [c_nodes];
  logic [c_iw-1:0]        r_cur_idx;
  logic [total_width-1:0] r_data;
  logic                   r_valid;
  logic                   r_done;
  logic [31:0]            r_sent;
  logic [31:0]            r_received;
  logic [31:0]            r_stall;
  logic [47:0]            r_lat_sum;
  logic [31:0]            r_max_lat;
  logic                   r_seq_err;

  logic [7:0]             w_rate;
  logic                   w_tick;
  logic                   w_hs;
  logic                   w_full;
  logic                   w_load;
  logic [dest_x-1:0]      w_dx;
  logic [dest_y-1:0]      w_dy;
  logic [c_iw-1:0]        w_dest_idx;
  logic [15:0]            w_seq;
  logic [15:0]            w_lfsr_next;
  logic [data_width-1:0]  w_payload;
  logic [total_width-1:0] w_flit;
  logic [source_x-1:0]    w_rx_sx;
  logic [source_y-1:0]    w_rx_sy;
  logic [31:0]            w_rx_ts;
  logic [15:0]            w_rx_seq;
  logic [31:0]            w_rx_src;
  logic                   w_rx_ok;
  logic [c_iw-1:0]        w_rx_idx;
  logic [31:0]            w_lat;
  logic                   w_unused;

  assign w_rate = (i_rate == 8'd0) ? 8'd1 : i_rate;
  assign w_tick = (r_state == S_RUN) && (r_tick == 8'd0);
  assign w_hs   = r_valid && i_ready;
  assign w_full = r_valid && !i_ready;
  assign w_load = w_tick && enable_send && !w_full && (r_loaded < 32'(num_of_pckts));

  always_comb begin
    w_dx = c_self_x;
    w_dy = c_self_y;
    case (mode)
      3'd1: w_dx = c_right_x;
      3'd2: w_dy = c_top_y;
      3'd3: begin
        if (r_lfsr[0]) w_dy = c_top_y;
        else           w_dx = c_right_x;
      end
      3'd4: begin
        w_dx = dest_x'(32'(r_lfsr[7:0]) % 32'(X));
        w_dy = dest_y'(32'(r_lfsr[15:8]) % 32'(Y));
      end
      3'd5: begin
        w_dx = c_tr_x;
        w_dy = c_tr_y;
      end
      default: ;
    endcase
  end

  assign w_dest_idx = c_iw'(32'(w_dy) * 32'(X) + 32'(w_dx));
  // A handshake on the same destination in the load cycle has not yet been
  // folded into tx_seq, so the new packet takes the post-increment value.
  assign w_seq = r_tx_seq[w_dest_idx] +
                 ((w_hs && (r_cur_idx == w_dest_idx)) ? 16'd1 : 16'd0);
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

  always_comb begin
    w_payload        = '0;
    w_payload[47:0]  = {w_seq, r_cycle};
  end

  assign w_flit = {w_payload, source_y'(ycord), source_x'(xcord), w_dy, w_dx};

  assign w_rx_sx  = i_data[c_sx_off +: source_x];
  assign w_rx_sy  = i_data[c_sy_off +: source_y];
  assign w_rx_ts  = i_data[c_pl_off +: 32];
  assign w_rx_seq = i_data[c_pl_off + 32 +: 16];
  assign w_rx_src = 32'(w_rx_sy) * 32'(X) + 32'(w_rx_sx);
  assign w_rx_ok  = w_rx_src < 32'(c_nodes);
  assign w_rx_idx = c_iw'(w_rx_src);
  assign w_lat    = r_cycle - w_rx_ts;
  assign w_unused = ^{i_data[c_sx_off-1:0], i_data[total_width-1:c_pl_off+47]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_tick     <= 8'd0;
      r_cycle    <= 32'd0;
      r_loaded   <= 32'd0;
      r_lfsr     <= lfsr_seed;
      r_cur_idx  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_sent     <= 32'd0;
      r_received <= 32'd0;
      r_stall    <= 32'd0;
      r_lat_sum  <= 48'd0;
      r_max_lat  <= 32'd0;
      r_seq_err  <= 1'b0;
      for (int i = 0; i < c_nodes; i++) begin
        r_tx_seq[i] <= 16'd0;
        r_rx_exp[i] <= 16'd0;
      end
    end else begin
      r_cycle <= r_cycle + 32'd1;

      if (i_valid) begin
        r_received <= r_received + 32'd1;
        r_lat_sum  <= r_lat_sum + 48'(w_lat);
        if (w_lat > r_max_lat) r_max_lat <= w_lat;
        if (w_rx_ok) begin
          if (w_rx_seq != r_rx_exp[w_rx_idx]) r_seq_err <= 1'b1;
          r_rx_exp[w_rx_idx] <= w_rx_seq + 16'd1;
        end
      end

      if (w_tick && w_full) r_stall <= r_stall + 32'd1;

      if (w_hs) begin
        r_sent              <= r_sent + 32'd1;
        r_tx_seq[r_cur_idx] <= r_tx_seq[r_cur_idx] + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_tick  <= 8'd0;
          end
        end
        S_RUN: begin
          r_tick <= (r_tick >= w_rate - 8'd1) ? 8'd0 : r_tick + 8'd1;
          if (w_hs && (r_sent == 32'(num_of_pckts) - 32'd1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase

      if (w_load) begin
        r_valid   <= 1'b1;
        r_data    <= w_flit;
        r_cur_idx <= w_dest_idx;
        r_lfsr    <= w_lfsr_next;
        r_loaded  <= r_loaded + 32'd1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data         = r_data;
  assign o_valid        = r_valid;
  assign done           = r_done;
  assign sent_count     = r_sent;
  assign received_count = r_received;
  assign stall_count    = r_stall;
  assign latency_sum    = r_lat_sum;
  assign max_latency    = r_max_lat;
  assign seq_error      = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_traffic_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_pe
// Brief    : Self-checking bench for traffic_pe (PE at (3,0) in a 4x4 mesh).
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_pe;

  localparam int NPK = 5;
  localparam int X0  = 3;
  localparam int Y0  = 0;
  localparam int TW  = 260;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          enable_send;
  logic [2:0]    mode;
  logic [7:0]    i_rate;
  logic [TW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic [TW-1:0] i_data;
  logic          i_valid;
  logic          done;
  logic [31:0]   sent_count;
  logic [31:0]   received_count;
  logic [31:0]   stall_count;
  logic [47:0]   latency_sum;
  logic [31:0]   max_latency;
  logic          seq_error;

  traffic_pe #(
    .xcord(X0), .ycord(Y0), .X(4), .Y(4), .num_of_pckts(NPK)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .enable_send(enable_send),
    .mode(mode), .i_rate(i_rate), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .i_data(i_data), .i_valid(i_valid), .done(done),
    .sent_count(sent_count), .received_count(received_count),
    .stall_count(stall_count), .latency_sum(latency_sum),
    .max_latency(max_latency), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int rx_mode  = 0;   // 0 idle, 1 loopback, 2 random injection, 3 manual

  // reference model state
  int            m_state;   // 0 idle, 1 run, 2 done
  int            m_tick;
  int            m_loaded;
  int            m_dest;
  bit            m_valid;
  logic [TW-1:0] m_data;
  logic [31:0]   m_sent, m_rcv, m_stall, m_max, m_cyc;
  logic [47:0]   m_lsum;
  bit            m_err;
  logic [15:0]   m_lfsr;
  logic [15:0]   m_tx [16];
  logic [15:0]   m_rx [16];
  bit            m_lb_v;
  logic [TW-1:0] m_lb_d;

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] mk_flit(input int dx, input int dy, input int sx,
                                             input int sy, input logic [15:0] seq,
                                             input logic [31:0] ts);
    logic [TW-1:0] f;
    f         = '0;
    f[1:0]    = 2'(dx);
    f[3:2]    = 2'(dy);
    f[11:4]   = 8'(sx);
    f[19:12]  = 8'(sy);
    f[51:20]  = ts;
    f[67:52]  = seq;
    return f;
  endfunction

  task automatic model_reset();
    m_state = 0; m_tick = 0; m_loaded = 0; m_dest = 0;
    m_valid = 1'b0; m_data = '0;
    m_sent = '0; m_rcv = '0; m_stall = '0; m_max = '0; m_cyc = '0; m_lsum = '0;
    m_err = 1'b0;
    m_lfsr = 16'hACE1 ^ 16'(Y0 * 4 + X0);
    for (int i = 0; i < 16; i++) begin m_tx[i] = '0; m_rx[i] = '0; end
    m_lb_v = 1'b0; m_lb_d = '0;
  endtask

  // One clock of the PE described by its rules: receive, handshake, then load.
  task automatic model_step();
    bit hs, full, tick, load;
    int pre, rate, dx, dy, d, src;
    logic [15:0] seq;
    logic [31:0] ts, lat;
    pre  = m_state;
    hs   = m_valid && i_ready;
    full = m_valid && !i_ready;
    tick = (pre == 1) && (m_tick == 0);
    rate = (i_rate == 8'd0) ? 1 : int'(i_rate);
    m_lb_v = hs;
    m_lb_d = m_data;
    if (i_valid) begin
      src = int'(i_data[19:12]) * 4 + int'(i_data[11:4]);
      ts  = i_data[51:20];
      seq = i_data[67:52];
      lat = m_cyc - ts;
      m_rcv  = m_rcv + 32'd1;
      m_lsum = m_lsum + {16'd0, lat};
      if (lat > m_max) m_max = lat;
      if (src < 16) begin
        if (seq != m_rx[src]) m_err = 1'b1;
        m_rx[src] = seq + 16'd1;
      end
    end
    if (tick && full) m_stall = m_stall + 32'd1;
    if (hs) begin
      m_sent = m_sent + 32'd1;
      m_tx[m_dest] = m_tx[m_dest] + 16'd1;
      if (m_sent == 32'(NPK)) m_state = 2;
    end
    load = tick && enable_send && !full && (m_loaded < NPK);
    if (load) begin
      dx = X0; dy = Y0;
      case (mode)
        3'd1: dx = (X0 + 1) % 4;
        3'd2: dy = (Y0 + 1) % 4;
        3'd3: if (m_lfsr[0]) dy = (Y0 + 1) % 4; else dx = (X0 + 1) % 4;
        3'd4: begin dx = int'(m_lfsr[7:0]) % 4; dy = int'(m_lfsr[15:8]) % 4; end
        3'd5: begin dx = Y0 % 4; dy = X0 % 4; end
        default: ;
      endcase
      d = dy * 4 + dx;
      m_data   = mk_flit(dx, dy, X0, Y0, m_tx[d], m_cyc);
      m_valid  = 1'b1;
      m_dest   = d;
      m_loaded = m_loaded + 1;
      m_lfsr   = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (pre == 0 && start) begin
      m_state = 1;
      m_tick  = 0;
    end else if (pre == 1) begin
      m_tick = (m_tick + 1 >= rate) ? 0 : m_tick + 1;
    end
    m_cyc = m_cyc + 32'd1;
  endtask

  always @(posedge clk) if (rstn) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_valid",        TW'(o_valid),        TW'(m_valid));
      chk("o_data",         o_data,              m_data);
      chk("done",           TW'(done),           TW'(m_state == 2));
      chk("sent_count",     TW'(sent_count),     TW'(m_sent));
      chk("received_count", TW'(received_count), TW'(m_rcv));
      chk("stall_count",    TW'(stall_count),    TW'(m_stall));
      chk("latency_sum",    TW'(latency_sum),    TW'(m_lsum));
      chk("max_latency",    TW'(max_latency),    TW'(m_max));
      chk("seq_error",      TW'(seq_error),      TW'(m_err));
    end
  end

  task automatic drive_rx();
    int sx, sy, src;
    logic [15:0] seq;
    logic [31:0] ts;
    logic [TW-1:0] f;
    case (rx_mode)
      0: i_valid = 1'b0;
      1: begin i_valid = m_lb_v; i_data = m_lb_d; end
      2: begin
        i_valid = ($urandom_range(0, 9) < 3);
        sx  = $urandom_range(0, 5);
        sy  = $urandom_range(0, 3);
        src = sy * 4 + sx;
        seq = 16'($urandom);
        if (src < 16 && $urandom_range(0, 1) == 1) seq = m_rx[src];
        ts = m_cyc - 32'($urandom_range(0, 60));
        if ($urandom_range(0, 9) == 0) ts = $urandom;
        f = mk_flit($urandom_range(0, 3), $urandom_range(0, 3), sx, sy, seq, ts);
        f[259:228] = $urandom;
        i_data = f;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    drive_rx();
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    model_reset();
    start = 1'b0; enable_send = 1'b1; i_ready = 1'b1; i_valid = 1'b0; rx_mode = 0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] d0;
    bit fin;
    rstn = 1'b0; start = 1'b0; enable_send = 1'b1; mode = 3'd0; i_rate = 8'd1;
    i_ready = 1'b1; i_valid = 1'b0; i_data = '0;
    model_reset();
    step();
    step();
    chk_en = 1'b1;
    chk("reset_o_valid", TW'(o_valid), TW'(0));
    chk("reset_o_data",  o_data,       TW'(0));
    chk("reset_done",    TW'(done),    TW'(0));
    chk("reset_sent",    TW'(sent_count), TW'(0));
    rstn = 1'b1;

    // RIGHT from (3,0) wraps to (0,0); back-to-back handshakes at rate 1
    mode = 3'd1; i_rate = 8'd1; i_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < NPK; k++) begin
      step();
      chk("a_valid", TW'(o_valid),      TW'(1));
      chk("a_dest",  TW'(o_data[3:0]),  TW'(0));
      chk("a_src",   TW'(o_data[11:4]), TW'(3));
      chk("a_seq",   TW'(o_data[67:52]), TW'(k));
      chk("a_done_low", TW'(done), TW'(0));
    end
    step();
    chk("a_done", TW'(done),    TW'(1));
    chk("a_idle", TW'(o_valid), TW'(0));
    do_reset();

    // backpressure: flit held, five dropped ticks at rate 2
    mode = 3'd2; i_rate = 8'd2; i_ready = 1'b0;
    pulse_start();
    step();
    d0 = o_data;
    chk("b_first_dest", TW'(d0[3:0]), TW'(4'b0111));
    for (int k = 0; k < 10; k++) begin
      step();
      chk("b_hold_valid", TW'(o_valid), TW'(1));
      chk("b_hold_data",  o_data,       d0);
    end
    chk("b_stall", TW'(stall_count), TW'(5));
    i_ready = 1'b1;
    step();
    chk("b_sent", TW'(sent_count), TW'(1));
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin step(); fin = (m_state == 2); end
    chk("b_done", TW'(done), TW'(1));
    do_reset();

    // loopback to self: every flit returns two cycles after its timestamp
    mode = 3'd0; i_rate = 8'd1; i_ready = 1'b1; rx_mode = 1;
    pulse_start();
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin step(); fin = (m_state == 2); end
    repeat (3) step();
    chk("c_rcv",     TW'(received_count), TW'(5));
    chk("c_max",     TW'(max_latency),    TW'(2));
    chk("c_sum",     TW'(latency_sum),    TW'(10));
    chk("c_seq_err", TW'(seq_error),      TW'(0));
    do_reset();

    // lost packet from source (1,2)
    rx_mode = 3;
    step(); i_valid = 1'b1; i_data = mk_flit(3, 0, 1, 2, 16'd0, m_cyc);
    step(); i_data = mk_flit(3, 0, 1, 2, 16'd1, m_cyc);
    chk("d_err0", TW'(seq_error), TW'(0));
    step(); i_data = mk_flit(3, 0, 1, 2, 16'd3, m_cyc);
    chk("d_err1", TW'(seq_error), TW'(0));
    step(); i_valid = 1'b0;
    chk("d_err2", TW'(seq_error),      TW'(1));
    chk("d_rcv",  TW'(received_count), TW'(3));
    do_reset();

    // asynchronous reset with a pending, blocked flit
    mode = 3'd1; i_rate = 8'd1; i_ready = 1'b0;
    pulse_start();
    repeat (3) step();
    chk("e_pending", TW'(o_valid), TW'(1));
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("e_valid", TW'(o_valid),     TW'(0));
    chk("e_data",  o_data,           TW'(0));
    chk("e_stall", TW'(stall_count), TW'(0));
    chk("e_sent",  TW'(sent_count),  TW'(0));
    step();
    rstn = 1'b1;

    // randomized runs over all modes, rates and receive traffic
    for (int run = 0; run < 16; run++) begin
      mode    = 3'($urandom_range(0, 7));
      i_rate  = 8'($urandom_range(0, 4));
      rx_mode = $urandom_range(0, 2);
      step();
      start = 1'b1;
      fin = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
        step();
        start       = ($urandom_range(0, 19) == 0);
        i_ready     = ($urandom_range(0, 9) < 7);
        enable_send = ($urandom_range(0, 9) < 8);
        fin = (m_state == 2);
      end
      chk("run_done", TW'(done), TW'(1));
      for (int c = 0; c < 6; c++) begin
        step();
        start   = ($urandom_range(0, 3) == 0);
        i_ready = ($urandom_range(0, 1) == 1);
      end
      do_reset();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
